// File: rtl/id_stage.sv
// RV32I instruction decode stage: 32x32 register file with write-through bypass,
// base-ISA decoder, load-use hazard detection and the ID->EX pipeline register.

module id_regfile #(
    parameter int NUM_RD = 2
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [4:0]             wadr_i,
    input  logic [31:0]            wdata_i,
    input  logic [NUM_RD-1:0][4:0] radr_i,
    output logic [NUM_RD-1:0][31:0] rdata_o
);
    // No reset on the array; x0 is never written and is forced to zero on read.
    logic [31:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (we_i && (wadr_i != 5'd0)) begin
            mem_q[wadr_i] <= wdata_i;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        always_comb begin
            rdata_o[p] = mem_q[radr_i[p]];
            if (radr_i[p] == 5'd0) begin
                rdata_o[p] = 32'd0;
            end else if (we_i && (wadr_i == radr_i[p])) begin
                rdata_o[p] = wdata_i;
            end
        end
    end
endmodule

module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_id,
    input  logic [29:0] pc_id,
    input  logic        stall,
    input  logic        rst_pipe,
    input  logic        jmp_flush,
    input  logic        wbk_en,
    input  logic [4:0]  wbk_adr,
    input  logic [31:0] wbk_data,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [31:0] imm_ex,
    output logic [4:0]  rd_adr_ex,
    output logic        rd_en_ex,
    output logic [29:0] pc_ex,
    output logic [2:0]  funct3_ex,
    output logic        funct7b5_ex,
    output logic        cmd_alu_ex,
    output logic        cmd_alui_ex,
    output logic        cmd_ld_ex,
    output logic        cmd_st_ex,
    output logic        cmd_br_ex,
    output logic        cmd_jal_ex,
    output logic        cmd_jalr_ex,
    output logic        cmd_lui_ex,
    output logic        cmd_auipc_ex,
    output logic        cmd_ecall_ex,
    output logic        cmd_mret_ex,
    output logic        illegal_ex,
    output logic        stall_ld
);
    typedef struct packed {
        logic alu;
        logic alui;
        logic ld;
        logic st;
        logic br;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic ecall;
        logic mret;
        logic illegal;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd_adr;
        logic        rd_en;
        logic [29:0] pc;
        logic [2:0]  funct3;
        logic        funct7b5;
        cmd_t        cmd;
    } ex_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [1:0][4:0]  rf_adr;
    logic [1:0][31:0] rf_data;

    cmd_t        dec_cmd;
    logic [31:0] dec_imm;
    logic        dec_rd_en, use_rs1, use_rs2, hazard;
    ex_t         dec, ex_d, ex_q;

    assign opcode = inst_id[6:0];
    assign rd     = inst_id[11:7];
    assign funct3 = inst_id[14:12];
    assign rs1    = inst_id[19:15];
    assign rs2    = inst_id[24:20];

    assign imm_i = {{20{inst_id[31]}}, inst_id[31:20]};
    assign imm_s = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
    assign imm_b = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
    assign imm_u = {inst_id[31:12], 12'b0};
    assign imm_j = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};

    assign rf_adr = {rs2, rs1};

    id_regfile #(.NUM_RD(2)) u_rf (
        .clk     (clk),
        .we_i    (wbk_en),
        .wadr_i  (wbk_adr),
        .wdata_i (wbk_data),
        .radr_i  (rf_adr),
        .rdata_o (rf_data)
    );

    always_comb begin
        dec_cmd = '0;
        dec_imm = 32'd0;
        case (opcode)
            7'b0110011: dec_cmd.alu = 1'b1;
            7'b0010011: begin dec_cmd.alui  = 1'b1; dec_imm = imm_i; end
            7'b0000011: begin dec_cmd.ld    = 1'b1; dec_imm = imm_i; end
            7'b0100011: begin dec_cmd.st    = 1'b1; dec_imm = imm_s; end
            7'b1100011: begin dec_cmd.br    = 1'b1; dec_imm = imm_b; end
            7'b1101111: begin dec_cmd.jal   = 1'b1; dec_imm = imm_j; end
            7'b1100111: begin dec_cmd.jalr  = 1'b1; dec_imm = imm_i; end
            7'b0110111: begin dec_cmd.lui   = 1'b1; dec_imm = imm_u; end
            7'b0010111: begin dec_cmd.auipc = 1'b1; dec_imm = imm_u; end
            7'b1110011: begin
                // Only ECALL and MRET are recognised in the SYSTEM space.
                if (funct3 == 3'b000 && inst_id[31:20] == 12'h000) begin
                    dec_cmd.ecall = 1'b1;
                end else if (funct3 == 3'b000 && inst_id[31:20] == 12'h302) begin
                    dec_cmd.mret = 1'b1;
                end else begin
                    dec_cmd.illegal = 1'b1;
                end
            end
            default: dec_cmd.illegal = 1'b1;
        endcase
    end

    assign dec_rd_en = (dec_cmd.alu | dec_cmd.alui | dec_cmd.ld | dec_cmd.jal |
                        dec_cmd.jalr | dec_cmd.lui | dec_cmd.auipc) & (rd != 5'd0);
    assign use_rs1   = dec_cmd.alu | dec_cmd.alui | dec_cmd.ld | dec_cmd.st |
                       dec_cmd.br | dec_cmd.jalr;
    assign use_rs2   = dec_cmd.alu | dec_cmd.st | dec_cmd.br;

    always_comb begin
        dec          = '0;
        dec.rs1_data = rf_data[0];
        dec.rs2_data = rf_data[1];
        dec.imm      = dec_imm;
        dec.rd_adr   = rd;
        dec.rd_en    = dec_rd_en;
        dec.pc       = pc_id;
        dec.funct3   = funct3;
        dec.funct7b5 = inst_id[30];
        dec.cmd      = dec_cmd;
    end

    // The bubble inserted on a hazard clears cmd.ld, so a hazard never lasts more than one cycle.
    assign hazard = ex_q.cmd.ld & ex_q.rd_en & (ex_q.rd_adr != 5'd0) &
                    ((use_rs1 & (rs1 == ex_q.rd_adr)) | (use_rs2 & (rs2 == ex_q.rd_adr)));
    assign stall_ld = hazard & ~stall;

    always_comb begin
        ex_d = dec;
        if (rst_pipe) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (jmp_flush || stall_ld) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign rs1_data_ex  = ex_q.rs1_data;
    assign rs2_data_ex  = ex_q.rs2_data;
    assign imm_ex       = ex_q.imm;
    assign rd_adr_ex    = ex_q.rd_adr;
    assign rd_en_ex     = ex_q.rd_en;
    assign pc_ex        = ex_q.pc;
    assign funct3_ex    = ex_q.funct3;
    assign funct7b5_ex  = ex_q.funct7b5;
    assign cmd_alu_ex   = ex_q.cmd.alu;
    assign cmd_alui_ex  = ex_q.cmd.alui;
    assign cmd_ld_ex    = ex_q.cmd.ld;
    assign cmd_st_ex    = ex_q.cmd.st;
    assign cmd_br_ex    = ex_q.cmd.br;
    assign cmd_jal_ex   = ex_q.cmd.jal;
    assign cmd_jalr_ex  = ex_q.cmd.jalr;
    assign cmd_lui_ex   = ex_q.cmd.lui;
    assign cmd_auipc_ex = ex_q.cmd.auipc;
    assign cmd_ecall_ex = ex_q.cmd.ecall;
    assign cmd_mret_ex  = ex_q.cmd.mret;
    assign illegal_ex   = ex_q.cmd.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage: expected EX bundles are queued as each
// instruction is presented and compared one cycle later.
module tb_id_stage;
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_en;
        logic [29:0] pc;
        logic [2:0]  f3;
        logic        f7b5;
        logic [11:0] cmd;
    } exp_t;
    localparam int EW = $bits(exp_t);

    localparam logic [11:0] C_ALU = 12'h800, C_ALUI = 12'h400, C_LD = 12'h200, C_ST = 12'h100,
                            C_BR = 12'h080, C_JAL = 12'h040, C_JALR = 12'h020, C_LUI = 12'h010,
                            C_AUIPC = 12'h008, C_ECALL = 12'h004, C_MRET = 12'h002, C_ILL = 12'h001;

    localparam logic [31:0] NOP = 32'h00000013, ADDI6 = 32'hFFF28313, ADD4 = 32'h00018233,
                            LW7 = 32'h0000A383, ADD8 = 32'h00238433, LW9 = 32'h00412483,
                            ADD10 = 32'h00908533, ADD12 = 32'h00058633, LW13 = 32'h0000A683,
                            ADD14 = 32'h00068733, BEQ = 32'h00208463, JAL1 = 32'hFFDFF0EF,
                            SWN = 32'hFE20AC23, LUI15 = 32'hABCDE7B7, AUIPC16 = 32'h00001817,
                            JALR0 = 32'h00008067, ECALL = 32'h00000073, MRET = 32'h30200073,
                            EBREAK = 32'h00100073, ALL1 = 32'hFFFFFFFF, ADD17 = 32'h000008B3;

    logic        clk = 1'b0;
    logic        rst_n, stall, rst_pipe, jmp_flush, wbk_en;
    logic [31:0] inst_id, wbk_data;
    logic [29:0] pc_id;
    logic [4:0]  wbk_adr;
    logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rd_adr_ex;
    logic        rd_en_ex, funct7b5_ex, stall_ld;
    logic [29:0] pc_ex;
    logic [2:0]  funct3_ex;
    logic        cmd_alu_ex, cmd_alui_ex, cmd_ld_ex, cmd_st_ex, cmd_br_ex, cmd_jal_ex;
    logic        cmd_jalr_ex, cmd_lui_ex, cmd_auipc_ex, cmd_ecall_ex, cmd_mret_ex, illegal_ex;

    exp_t        act, last_e;
    exp_t        sb[$];
    logic [31:0] rf_m [32];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .pc_id(pc_id), .stall(stall),
        .rst_pipe(rst_pipe), .jmp_flush(jmp_flush), .wbk_en(wbk_en), .wbk_adr(wbk_adr),
        .wbk_data(wbk_data), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .imm_ex(imm_ex), .rd_adr_ex(rd_adr_ex), .rd_en_ex(rd_en_ex), .pc_ex(pc_ex),
        .funct3_ex(funct3_ex), .funct7b5_ex(funct7b5_ex), .cmd_alu_ex(cmd_alu_ex),
        .cmd_alui_ex(cmd_alui_ex), .cmd_ld_ex(cmd_ld_ex), .cmd_st_ex(cmd_st_ex),
        .cmd_br_ex(cmd_br_ex), .cmd_jal_ex(cmd_jal_ex), .cmd_jalr_ex(cmd_jalr_ex),
        .cmd_lui_ex(cmd_lui_ex), .cmd_auipc_ex(cmd_auipc_ex), .cmd_ecall_ex(cmd_ecall_ex),
        .cmd_mret_ex(cmd_mret_ex), .illegal_ex(illegal_ex), .stall_ld(stall_ld)
    );

    assign act = {rs1_data_ex, rs2_data_ex, imm_ex, rd_adr_ex, rd_en_ex, pc_ex, funct3_ex,
                  funct7b5_ex, cmd_alu_ex, cmd_alui_ex, cmd_ld_ex, cmd_st_ex, cmd_br_ex,
                  cmd_jal_ex, cmd_jalr_ex, cmd_lui_ex, cmd_auipc_ex, cmd_ecall_ex,
                  cmd_mret_ex, illegal_ex};

    task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Expected EX bundle for a decoded instruction; operands come from the reference register model.
    function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] imm,
                                input logic [11:0] cmd, input logic rd_en);
        exp_t e;
        e.rs1   = rf_m[inst[19:15]];
        e.rs2   = rf_m[inst[24:20]];
        e.imm   = imm;
        e.rd    = inst[11:7];
        e.rd_en = rd_en;
        e.pc    = pc_id;
        e.f3    = inst[14:12];
        e.f7b5  = inst[30];
        e.cmd   = cmd;
        return e;
    endfunction

    task automatic id(input logic [31:0] inst);
        inst_id = inst;
        pc_id   = pc_id + 30'd1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wbk_en   = 1'b1;
        wbk_adr  = a;
        wbk_data = d;
        if (a != 5'd0) rf_m[a] = d;
    endtask

    task automatic step(input string tag, input exp_t e, input logic exp_stall);
        exp_t q;
        #1 chk({tag, "_stall_ld"}, EW'(stall_ld), EW'(exp_stall));
        sb.push_back(e);
        last_e = e;
        @(posedge clk);
        #1;
        q = sb.pop_front();
        chk(tag, act, q);
        wbk_en = 1'b0; stall = 1'b0; jmp_flush = 1'b0; rst_pipe = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; rst_pipe = 1'b0; jmp_flush = 1'b0;
        wbk_en = 1'b0; wbk_adr = 5'd0; wbk_data = 32'd0;
        inst_id = NOP; pc_id = 30'd0; last_e = '0;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;

        #12;
        chk("reset_outputs", act, '0);
        chk("reset_stall_ld", EW'(stall_ld), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i < 32; i++) begin
            id(NOP); wb(5'(i), 32'h1000_0000 | (i * 32'h0001_0101));
            step("init_wb", mk(NOP, 32'd0, C_ALUI, 1'b0), 1'b0);
        end

        id(NOP); wb(5'd5, 32'h1234_5678);
        step("wb_x5", mk(NOP, 32'd0, C_ALUI, 1'b0), 1'b0);
        id(ADDI6);
        step("addi_x6", mk(ADDI6, 32'hFFFF_FFFF, C_ALUI, 1'b1), 1'b0);

        id(ADD4); wb(5'd3, 32'hA5A5_A5A5);
        step("bypass_add_x4", mk(ADD4, 32'd0, C_ALU, 1'b1), 1'b0);

        id(LW7);
        step("lw_x7", mk(LW7, 32'd0, C_LD, 1'b1), 1'b0);
        id(ADD8);
        step("ld_use_rs1_bubble", '0, 1'b1);
        step("ld_use_rs1_issue", mk(ADD8, 32'd0, C_ALU, 1'b1), 1'b0);

        id(LW9);
        step("lw_x9", mk(LW9, 32'd4, C_LD, 1'b1), 1'b0);
        id(ADD10); stall = 1'b1; wb(5'd11, 32'hCAFE_BABE);
        step("stall_hold", last_e, 1'b0);
        step("ld_use_rs2_bubble", '0, 1'b1);
        step("ld_use_rs2_issue", mk(ADD10, 32'd0, C_ALU, 1'b1), 1'b0);
        id(ADD12);
        step("wb_during_stall", mk(ADD12, 32'd0, C_ALU, 1'b1), 1'b0);

        id(LW13);
        step("lw_x13", mk(LW13, 32'd0, C_LD, 1'b1), 1'b0);
        id(ADD14); jmp_flush = 1'b1;
        step("flush_with_ld_use", '0, 1'b1);

        id(BEQ);
        step("beq", mk(BEQ, 32'd8, C_BR, 1'b0), 1'b0);
        id(BEQ); jmp_flush = 1'b1;
        step("beq_flushed", '0, 1'b0);

        id(JAL1);
        step("jal_x1_m4", mk(JAL1, 32'hFFFF_FFFC, C_JAL, 1'b1), 1'b0);
        id(SWN);
        step("sw_neg", mk(SWN, 32'hFFFF_FFF8, C_ST, 1'b0), 1'b0);
        id(LUI15);
        step("lui", mk(LUI15, 32'hABCD_E000, C_LUI, 1'b1), 1'b0);
        id(AUIPC16);
        step("auipc", mk(AUIPC16, 32'h0000_1000, C_AUIPC, 1'b1), 1'b0);
        id(JALR0);
        step("jalr_x0", mk(JALR0, 32'd0, C_JALR, 1'b0), 1'b0);
        id(ECALL);
        step("ecall", mk(ECALL, 32'd0, C_ECALL, 1'b0), 1'b0);
        id(MRET);
        step("mret", mk(MRET, 32'd0, C_MRET, 1'b0), 1'b0);
        id(EBREAK);
        step("ebreak_illegal", mk(EBREAK, 32'd0, C_ILL, 1'b0), 1'b0);
        id(ALL1); wb(5'd0, 32'hDEAD_BEEF);
        step("all_ones_illegal", mk(ALL1, 32'd0, C_ILL, 1'b0), 1'b0);
        id(ADD17);
        step("x0_reads_zero", mk(ADD17, 32'd0, C_ALU, 1'b1), 1'b0);

        id(ADD4); rst_pipe = 1'b1; stall = 1'b1;
        step("rst_pipe_over_stall", '0, 1'b0);
        id(ADD4);
        step("rf_kept_after_rst_pipe", mk(ADD4, 32'd0, C_ALU, 1'b1), 1'b0);

        id(LW9);
        step("lw_before_async_rst", mk(LW9, 32'd4, C_LD, 1'b1), 1'b0);
        id(ADD10); stall = 1'b1;
        #1 chk("stall_masks_ld", EW'(stall_ld), '0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outputs", act, '0);
        chk("async_rst_stall_ld", EW'(stall_ld), '0);
        @(posedge clk);
        #1 rst_n = 1'b1; stall = 1'b0;
        step("issue_after_async_rst", mk(ADD10, 32'd0, C_ALU, 1'b1), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
